// File: rtl/ipu_pkg.sv
// Shared IPU definitions: complex word widths and index-width helper.
package ipu_pkg;

    localparam int unsigned SZ32 = 32;
    localparam int unsigned SZ64 = 64;

    // Width of one {real,imag} complex word for the selected precision.
    function automatic int unsigned cplx_width(input int unsigned double);
        return (double != 0) ? 2 * SZ64 : 2 * SZ32;
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/comp_add.sv
// Combinational complex IEEE-754 adder, round-to-nearest-even on each half.
module comp_add
    import ipu_pkg::*;
#(
    parameter int unsigned double = 0
) (
    input  logic [cplx_width(double)-1:0] a,
    input  logic [cplx_width(double)-1:0] b,
    output logic [cplx_width(double)-1:0] result
);

    localparam int unsigned W  = cplx_width(double);
    localparam int unsigned SZ = W / 2;
    localparam int unsigned EW = (double != 0) ? 11 : 8;
    localparam int unsigned FW = SZ - EW - 1;
    localparam int unsigned MW = FW + 1;
    localparam int unsigned XW = MW + 3;

    function automatic logic [SZ-1:0] fp_add(input logic [SZ-1:0] x, input logic [SZ-1:0] y);
        logic          sx, sy;
        logic [EW-1:0] ex, ey;
        logic [FW-1:0] fx, fy;
        logic [XW-1:0] ma, mb;
        logic [XW:0]   s;
        logic [EW+1:0] e, e_y, d;
        logic [MW:0]   m;
        logic          sticky, up;
        {sx, ex, fx} = x;
        {sy, ey, fy} = y;
        if (ex == '1 || ey == '1) begin
            if (ex == '1 && fx != '0) return x | {{(EW + 1){1'b0}}, 1'b1, {(FW - 1){1'b0}}};
            if (ey == '1 && fy != '0) return y | {{(EW + 1){1'b0}}, 1'b1, {(FW - 1){1'b0}}};
            if (ex == '1 && ey == '1 && sx != sy) return {1'b0, {EW{1'b1}}, 1'b1, {(FW - 1){1'b0}}};
            return (ex == '1) ? x : y;
        end
        // Larger magnitude first so the aligned subtraction never goes negative.
        if ({ey, fy} > {ex, fx})
            {sx, ex, fx, sy, ey, fy} = {sy, ey, fy, sx, ex, fx};
        ma  = {ex != '0, fx, 3'b000};
        mb  = {ey != '0, fy, 3'b000};
        e   = (ex == '0) ? (EW + 2)'(1) : {2'b00, ex};
        e_y = (ey == '0) ? (EW + 2)'(1) : {2'b00, ey};
        d   = e - e_y;
        sticky = 1'b0;
        for (int unsigned i = 0; i < XW; i++)
            if (i < 32'(d)) sticky |= mb[i];
        mb = (32'(d) >= XW) ? '0 : (mb >> d);
        mb[0] = mb[0] | sticky;
        s = (sx == sy) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
        if (s == '0) return {sx & sy, {(SZ - 1){1'b0}}};
        if (s[XW]) begin
            s = {1'b0, s[XW:2], s[1] | s[0]};
            e = e + 1'b1;
        end
        for (int unsigned i = 0; i < XW; i++)
            if (!s[XW-1] && e > (EW + 2)'(1)) begin
                s = s << 1;
                e = e - 1'b1;
            end
        up = s[2] & (s[1] | s[0] | s[3]);
        m  = {1'b0, s[XW-1:3]} + (MW + 1)'(up);
        if (m[MW]) begin
            m = m >> 1;
            e = e + 1'b1;
        end
        if (e >= (EW + 2)'((1 << EW) - 1)) return {sx, {EW{1'b1}}, {FW{1'b0}}};
        return {sx, m[MW-1] ? e[EW-1:0] : {EW{1'b0}}, m[FW-1:0]};
    endfunction

    always_comb begin
        result = {fp_add(a[W-1:SZ], b[W-1:SZ]), fp_add(a[SZ-1:0], b[SZ-1:0])};
    end

endmodule

// File: rtl/comp_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter
    import ipu_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     en,
    output logic [NREQ-1:0]          grant,
    output logic [clog2(NREQ)-1:0]   grant_idx
);

    localparam int unsigned IDW = clog2(NREQ);

    logic [IDW-1:0] ptr;

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= IDW'(NREQ - 1);
        else if (en && |req)
            ptr <= grant_idx;
    end

endmodule

// File: rtl/comp_add_arbiter.sv
// Shares one comp_add among NREQ requesters: RR grant, operand/result registers.
module comp_add_arbiter
    import ipu_pkg::*;
#(
    parameter int unsigned double = 0,
    parameter int unsigned NREQ   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ*cplx_width(double)-1:0]  req_a,
    input  logic [NREQ*cplx_width(double)-1:0]  req_b,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [clog2(NREQ)-1:0]              rsp_id,
    output logic [cplx_width(double)-1:0]       rsp_result,
    output logic                                busy
);

    localparam int unsigned W   = cplx_width(double);
    localparam int unsigned IDW = clog2(NREQ);

    logic           s0_v, s1_v;
    logic [W-1:0]   s0_a, s0_b, s1_result, sum;
    logic [IDW-1:0] s0_id, s1_id;
    logic           s0_free, s1_free, accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;

    assign s1_free = !s1_v || rsp_ready;
    assign s0_free = !s0_v || s1_free;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (s0_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    comp_add #(.double(double)) u_add (
        .a      (s0_a),
        .b      (s0_b),
        .result (sum)
    );

    // Grant is already a subset of req_valid, so ready never leads valid.
    always_comb begin
        req_ready = rst ? '0 : (grant & {NREQ{s0_free}});
        accept    = |req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v      <= 1'b0;
            s0_a      <= '0;
            s0_b      <= '0;
            s0_id     <= '0;
            s1_v      <= 1'b0;
            s1_result <= '0;
            s1_id     <= '0;
        end else begin
            if (s1_free) begin
                s1_v      <= s0_v;
                s1_result <= sum;
                s1_id     <= s0_id;
            end
            if (s0_free) begin
                s0_v <= accept;
                if (accept) begin
                    s0_a  <= req_a[grant_idx*W +: W];
                    s0_b  <= req_b[grant_idx*W +: W];
                    s0_id <= grant_idx;
                end
            end
        end
    end

    assign rsp_valid  = s1_v;
    assign rsp_id     = s1_id;
    assign rsp_result = s1_result;
    assign busy       = s0_v | s1_v;

endmodule

// File: tb/tb_comp_add_arbiter.sv
// Randomised bench for comp_add_arbiter with a transaction-level scoreboard.
module tb_comp_add_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 64;
    localparam int unsigned IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;

    logic [1:0]        d_req_valid, d_req_ready;
    logic [255:0]      d_req_a, d_req_b;
    logic              d_rsp_valid, d_rsp_ready, d_busy;
    logic [0:0]        d_rsp_id;
    logic [127:0]      d_rsp_result;

    comp_add_arbiter #(.double(0), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    comp_add_arbiter #(.double(1), .NREQ(2)) dut64 (
        .clk(clk), .rst(rst), .req_valid(d_req_valid), .req_ready(d_req_ready),
        .req_a(d_req_a), .req_b(d_req_b), .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready),
        .rsp_id(d_rsp_id), .rsp_result(d_rsp_result), .busy(d_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact float encodings of small integers; sums of such stay exact.
    function automatic logic [31:0] i2f32(input int v);
        int unsigned m, p;
        if (v == 0) return '0;
        m = (v < 0) ? int'(-v) : v;
        p = 0;
        for (int unsigned k = 0; k < 31; k++)
            if ((m >> k) != 0) p = k;
        return {v < 0, 8'(127 + p), 23'(m << (23 - p))};
    endfunction

    function automatic logic [63:0] i2f64(input int v);
        int unsigned m, p;
        if (v == 0) return '0;
        m = (v < 0) ? int'(-v) : v;
        p = 0;
        for (int unsigned k = 0; k < 31; k++)
            if ((m >> k) != 0) p = k;
        return {v < 0, 11'(1023 + p), 52'(64'(m) << (52 - p))};
    endfunction

    typedef struct {
        int          id;
        logic [W-1:0] res;
        int unsigned acc;
    } op_t;

    op_t          q[$];
    logic [W-1:0] op_a[NREQ], op_b[NREQ], op_exp[NREQ];
    bit           pend[NREQ], act[NREQ], cont[NREQ];
    int unsigned  refill_pct, rdy_pct, ptr, cyc, wait2;
    bit           rst_req, fair_mode, watch2;

    task automatic new_op(input int i);
        int ra, ia, rb, ib;
        ra = int'($urandom_range(2000)) - 1000;
        ia = int'($urandom_range(2000)) - 1000;
        rb = int'($urandom_range(2000)) - 1000;
        ib = int'($urandom_range(2000)) - 1000;
        op_a[i]   = {i2f32(ra), i2f32(ia)};
        op_b[i]   = {i2f32(rb), i2f32(ib)};
        op_exp[i] = {i2f32(ra + rb), i2f32(ia + ib)};
        pend[i]   = 1'b1;
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        bit free, exp_rv;
        int g, j;
        @(negedge clk);
        rst = rst_req;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]    = pend[i];
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
        rsp_ready = ($urandom_range(99) < rdy_pct);
        if (fair_mode && pend[2] && !watch2) begin
            watch2 = 1'b1;
            wait2  = 0;
        end
        #1;
        free = (q.size() < 2) || rsp_ready;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (g < 0 && pend[j]) g = j;
        end
        exp_rdy = '0;
        if (!rst && free && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        exp_rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("rsp_valid", rsp_valid, exp_rv);
        check("busy", busy, q.size() != 0);
        if (exp_rv) begin
            check("rsp_id", rsp_id, q[0].id);
            check("rsp_result", rsp_result, q[0].res);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            ptr = NREQ - 1;
        end else begin
            if (exp_rv && rsp_ready) void'(q.pop_front());
            if (exp_rdy != '0) begin
                q.push_back('{id: g, res: op_exp[g], acc: cyc});
                ptr = g;
                pend[g] = 1'b0;
                if (watch2) begin
                    if (g == 2) begin
                        check("fairness_wait", wait2 <= NREQ - 1, 1);
                        watch2 = 1'b0;
                    end else begin
                        wait2++;
                    end
                end
                if (cont[g]) new_op(g);
            end
            for (int i = 0; i < NREQ; i++)
                if (i != g && act[i] && !pend[i] && $urandom_range(99) < refill_pct)
                    new_op(i);
        end
        cyc++;
    endtask

    task automatic set_all(input bit a, input bit c);
        for (int i = 0; i < NREQ; i++) begin
            act[i]  = a;
            cont[i] = c;
        end
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        d_req_valid = '0; d_req_a = '0; d_req_b = '0; d_rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; op_exp[i] = '0;
        end
        set_all(1'b0, 1'b0);
        ptr = NREQ - 1; cyc = 0; wait2 = 0;
        rst_req = 1'b1; fair_mode = 1'b0; watch2 = 1'b0;
        refill_pct = 100; rdy_pct = 100;

        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = '1;
        #1;
        check("reset_req_ready", req_ready, '0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_busy", busy, 0);
        check("reset_d_rsp_valid", d_rsp_valid, 0);
        req_valid = '0;
        step();
        rst_req = 1'b0;

        // Single directed op on requester 0.
        op_a[0]   = 64'h3F800000_40000000;
        op_b[0]   = 64'h40400000_40800000;
        op_exp[0] = 64'h40800000_40C00000;
        pend[0]   = 1'b1;
        repeat (4) step();

        // All requesters continuously valid, full throughput.
        set_all(1'b1, 1'b1);
        for (int i = 0; i < NREQ; i++) new_op(i);
        repeat (18) step();

        // Backpressure then release.
        rdy_pct = 0;
        repeat (5) step();
        rdy_pct = 100;
        repeat (6) step();

        // Drain, then fairness: req2 held, req0 toggling, random stalls.
        set_all(1'b0, 1'b0);
        repeat (8) step();
        act[0] = 1'b1; act[2] = 1'b1; cont[2] = 1'b1;
        fair_mode = 1'b1; rdy_pct = 50;
        new_op(0); new_op(2);
        repeat (40) step();
        fair_mode = 1'b0; watch2 = 1'b0;

        // Random traffic.
        set_all(1'b1, 1'b0);
        refill_pct = 40; rdy_pct = 70;
        repeat (300) step();

        // Reset with both stages full; only 1 and 3 request afterwards.
        set_all(1'b1, 1'b1);
        refill_pct = 100; rdy_pct = 0;
        for (int i = 0; i < NREQ; i++) if (!pend[i]) new_op(i);
        repeat (4) step();
        act[0] = 1'b0; act[2] = 1'b0; pend[0] = 1'b0; pend[2] = 1'b0;
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0; rdy_pct = 100;
        set_all(1'b0, 1'b0);
        repeat (8) step();

        // Double precision instance.
        @(negedge clk);
        d_req_valid = 2'b01;
        d_req_a[127:0] = {64'h3FF8000000000000, 64'hC000000000000000};
        d_req_b[127:0] = {64'h3FE0000000000000, 64'h4000000000000000};
        d_rsp_ready = 1'b1;
        #1 check("d_req_ready0", d_req_ready, 2'b01);
        @(negedge clk);
        d_req_valid = 2'b10;
        d_req_a[255:128] = {i2f64(7), i2f64(-3)};
        d_req_b[255:128] = {i2f64(-2), i2f64(10)};
        #1 check("d_rsp_valid_lat1", d_rsp_valid, 0);
        check("d_req_ready1", d_req_ready, 2'b10);
        @(negedge clk);
        d_req_valid = 2'b00;
        #1 check("d_rsp_valid_lat2", d_rsp_valid, 1);
        check("d_rsp_id0", d_rsp_id, 0);
        check("d_rsp_result0", d_rsp_result, 128'h40000000000000000000000000000000);
        @(negedge clk);
        #1 check("d_rsp_valid_b", d_rsp_valid, 1);
        check("d_rsp_id1", d_rsp_id, 1);
        check("d_rsp_result1", d_rsp_result, {i2f64(5), i2f64(7)});
        @(negedge clk);
        #1 check("d_busy_idle", d_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
